// File: rtl/tbus_defs.sv
// rtl/tbus_defs.sv - shared trinity bus widths, operation codes and arbiter state encodings
package tbus_defs;

    localparam int RESULT_RANGE = 64;
    localparam int SRC_RANGE    = 64;
    localparam int TBUS_RANGE   = 2;

    localparam logic [TBUS_RANGE-1:0] TBUS_READ  = 2'b00;
    localparam logic [TBUS_RANGE-1:0] TBUS_WRITE = 2'b01;

    // Requester identity as stored in last_grant / owner.
    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/tbus_rr_pick.sv
// rtl/tbus_rr_pick.sv - two-way round-robin pick, purely combinational
module tbus_rr_pick
    import tbus_defs::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Bit 0 is icache, bit 1 is dcache; a tie goes to whoever did not win last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == GRANT_ICACHE) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/tbus_arbiter.sv
// rtl/tbus_arbiter.sv - round-robin sharing of the DDR trinity bus between icache and dcache
module tbus_arbiter
    import tbus_defs::*;
(
    input  logic                    clock,
    input  logic                    reset_n,

    input  logic                    icache2arb_tbus_index_valid,
    output logic                    icache2arb_tbus_index_ready,
    input  logic [SRC_RANGE-1:0]    icache2arb_tbus_index,
    input  logic [SRC_RANGE-1:0]    icache2arb_tbus_write_data,
    input  logic [SRC_RANGE-1:0]    icache2arb_tbus_write_mask,
    input  logic [TBUS_RANGE-1:0]   icache2arb_tbus_operation_type,
    output logic [RESULT_RANGE-1:0] icache2arb_tbus_read_data,
    output logic                    icache2arb_tbus_operation_done,

    input  logic                    dcache2arb_tbus_index_valid,
    output logic                    dcache2arb_tbus_index_ready,
    input  logic [SRC_RANGE-1:0]    dcache2arb_tbus_index,
    input  logic [SRC_RANGE-1:0]    dcache2arb_tbus_write_data,
    input  logic [SRC_RANGE-1:0]    dcache2arb_tbus_write_mask,
    input  logic [TBUS_RANGE-1:0]   dcache2arb_tbus_operation_type,
    output logic [RESULT_RANGE-1:0] dcache2arb_tbus_read_data,
    output logic                    dcache2arb_tbus_operation_done,

    output logic                    ddr_tbus_index_valid,
    input  logic                    ddr_tbus_index_ready,
    output logic [SRC_RANGE-1:0]    ddr_tbus_index,
    output logic [SRC_RANGE-1:0]    ddr_tbus_write_data,
    output logic [SRC_RANGE-1:0]    ddr_tbus_write_mask,
    output logic [TBUS_RANGE-1:0]   ddr_tbus_operation_type,
    input  logic [RESULT_RANGE-1:0] ddr_tbus_read_data,
    input  logic                    ddr_tbus_operation_done
);

    arb_state_t state, next_state;
    logic       last_grant;
    logic       owner;
    logic [1:0] grant;
    logic       accept_i, accept_d, complete;

    tbus_rr_pick u_pick (
        .req        ({dcache2arb_tbus_index_valid, icache2arb_tbus_index_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is gated with reset_n so nothing handshakes while reset is asserted.
    always_comb begin
        next_state = state;
        accept_i   = 1'b0;
        accept_d   = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                accept_i = grant[0] & reset_n;
                accept_d = grant[1] & reset_n;
                if (accept_i || accept_d) next_state = ISSUE;
            end
            ISSUE: begin
                if (ddr_tbus_index_ready) begin
                    if (ddr_tbus_operation_done) begin
                        complete   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (ddr_tbus_operation_done) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            last_grant              <= GRANT_ICACHE;
            owner                   <= GRANT_ICACHE;
            ddr_tbus_index          <= '0;
            ddr_tbus_write_data     <= '0;
            ddr_tbus_write_mask     <= '0;
            ddr_tbus_operation_type <= '0;
        end else begin
            state <= next_state;
            if (accept_d) begin
                owner                   <= GRANT_DCACHE;
                last_grant              <= GRANT_DCACHE;
                ddr_tbus_index          <= dcache2arb_tbus_index;
                ddr_tbus_write_data     <= dcache2arb_tbus_write_data;
                ddr_tbus_write_mask     <= dcache2arb_tbus_write_mask;
                ddr_tbus_operation_type <= dcache2arb_tbus_operation_type;
            end else if (accept_i) begin
                owner                   <= GRANT_ICACHE;
                last_grant              <= GRANT_ICACHE;
                ddr_tbus_index          <= icache2arb_tbus_index;
                ddr_tbus_write_data     <= icache2arb_tbus_write_data;
                ddr_tbus_write_mask     <= icache2arb_tbus_write_mask;
                ddr_tbus_operation_type <= icache2arb_tbus_operation_type;
            end
        end
    end

    assign ddr_tbus_index_valid           = (state == ISSUE);
    assign icache2arb_tbus_index_ready    = accept_i;
    assign dcache2arb_tbus_index_ready    = accept_d;
    assign icache2arb_tbus_operation_done = complete && (owner == GRANT_ICACHE);
    assign dcache2arb_tbus_operation_done = complete && (owner == GRANT_DCACHE);
    assign icache2arb_tbus_read_data      = icache2arb_tbus_operation_done ? ddr_tbus_read_data : '0;
    assign dcache2arb_tbus_read_data      = dcache2arb_tbus_operation_done ? ddr_tbus_read_data : '0;

endmodule

// File: tb/tb_tbus_arbiter.sv
// tb/tb_tbus_arbiter.sv - randomized and directed self-checking bench for tbus_arbiter
module tb_tbus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iv, dv, ddr_ready, ddr_done;
    logic        i_ready, d_ready, i_done, d_done, ddr_valid;
    logic [63:0] i_idx, i_wd, i_mask, d_idx, d_wd, d_mask, ddr_rdata;
    logic [63:0] i_rdata, d_rdata, ddr_idx, ddr_wd, ddr_mask;
    logic [1:0]  i_type, d_type, ddr_type;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a pending transaction and the stage it has reached.
    int          phase;      // 0 none, 1 waiting for DDR accept, 2 waiting for DDR done
    logic        m_owner_d;
    logic        m_last_d;
    logic [63:0] m_idx, m_wd, m_mask;
    logic [1:0]  m_type;

    always #5 clock = ~clock;

    tbus_arbiter dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .icache2arb_tbus_index_valid    (iv),
        .icache2arb_tbus_index_ready    (i_ready),
        .icache2arb_tbus_index          (i_idx),
        .icache2arb_tbus_write_data     (i_wd),
        .icache2arb_tbus_write_mask     (i_mask),
        .icache2arb_tbus_operation_type (i_type),
        .icache2arb_tbus_read_data      (i_rdata),
        .icache2arb_tbus_operation_done (i_done),
        .dcache2arb_tbus_index_valid    (dv),
        .dcache2arb_tbus_index_ready    (d_ready),
        .dcache2arb_tbus_index          (d_idx),
        .dcache2arb_tbus_write_data     (d_wd),
        .dcache2arb_tbus_write_mask     (d_mask),
        .dcache2arb_tbus_operation_type (d_type),
        .dcache2arb_tbus_read_data      (d_rdata),
        .dcache2arb_tbus_operation_done (d_done),
        .ddr_tbus_index_valid           (ddr_valid),
        .ddr_tbus_index_ready           (ddr_ready),
        .ddr_tbus_index                 (ddr_idx),
        .ddr_tbus_write_data            (ddr_wd),
        .ddr_tbus_write_mask            (ddr_mask),
        .ddr_tbus_operation_type        (ddr_type),
        .ddr_tbus_read_data             (ddr_rdata),
        .ddr_tbus_operation_done        (ddr_done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Winner as {dcache, icache}: a lone requester wins, a tie goes to the one not served last.
    function automatic logic [1:0] pick_winner(input logic i, input logic d, input logic last_d);
        if (i && d) return last_d ? 2'b01 : 2'b10;
        return {d, i};
    endfunction

    task automatic model_reset();
        phase     = 0;
        m_owner_d = 1'b0;
        m_last_d  = 1'b0;
        m_idx = '0; m_wd = '0; m_mask = '0; m_type = '0;
    endtask

    task automatic check_all();
        logic [1:0]  w;
        logic        fin;
        logic [63:0] zero64;
        zero64 = '0;
        w   = (reset_n && phase == 0) ? pick_winner(iv, dv, m_last_d) : 2'b00;
        fin = reset_n && ((phase == 1 && ddr_ready && ddr_done) || (phase == 2 && ddr_done));
        check_val("i_ready", {63'd0, i_ready}, {63'd0, w[0]});
        check_val("d_ready", {63'd0, d_ready}, {63'd0, w[1]});
        check_val("i_done", {63'd0, i_done}, {63'd0, fin && !m_owner_d});
        check_val("d_done", {63'd0, d_done}, {63'd0, fin && m_owner_d});
        check_val("i_rdata", i_rdata, (fin && !m_owner_d) ? ddr_rdata : zero64);
        check_val("d_rdata", d_rdata, (fin && m_owner_d) ? ddr_rdata : zero64);
        check_val("ddr_valid", {63'd0, ddr_valid}, {63'd0, reset_n && phase == 1});
        if (!reset_n || phase == 1) begin
            check_val("ddr_idx", ddr_idx, m_idx);
            check_val("ddr_wd", ddr_wd, m_wd);
            check_val("ddr_mask", ddr_mask, m_mask);
            check_val("ddr_type", {62'd0, ddr_type}, {62'd0, m_type});
        end
    endtask

    task automatic model_update();
        logic [1:0] w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (phase)
            0: begin
                w = pick_winner(iv, dv, m_last_d);
                if (w != 2'b00) begin
                    m_owner_d = w[1];
                    m_last_d  = w[1];
                    m_idx  = w[1] ? d_idx  : i_idx;
                    m_wd   = w[1] ? d_wd   : i_wd;
                    m_mask = w[1] ? d_mask : i_mask;
                    m_type = w[1] ? d_type : i_type;
                    phase  = 1;
                end
            end
            1: if (ddr_ready) phase = ddr_done ? 0 : 2;
            2: if (ddr_done) phase = 0;
            default: phase = 0;
        endcase
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_ddr(input logic r, input logic d, input logic [63:0] data);
        ddr_ready = r; ddr_done = d; ddr_rdata = data;
    endtask

    initial begin
        reset_n = 1'b0;
        iv = 1'b1; dv = 1'b1;
        i_idx = 64'h1111; i_wd = 64'h2222; i_mask = 64'h3333; i_type = 2'b00;
        d_idx = 64'h4444; d_wd = 64'h5555; d_mask = 64'h6666; d_type = 2'b01;
        set_ddr(1'b0, 1'b1, 64'hAAAA);
        model_reset();
        step(); step();

        // Tie on the first cycle after reset, then alternating grants with single-cycle DDR service.
        reset_n = 1'b1;
        set_ddr(1'b0, 1'b0, 64'h0);
        step();
        for (int k = 0; k < 6; k++) begin
            set_ddr(1'b1, 1'b1, 64'h100 + 64'(k));
            step();
            set_ddr(1'b0, 1'b0, 64'h0);
            step();
        end

        // Lone dcache read: ready at T+1, done at T+3.
        iv = 1'b0; dv = 1'b1;
        d_idx = 64'h8000_1000; d_type = 2'b00;
        step();
        dv = 1'b0;
        set_ddr(1'b1, 1'b0, 64'h0); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();
        set_ddr(1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();

        // dcache write stalled by DDR for 5 cycles while icache waits.
        dv = 1'b1; d_idx = 64'h8000_2000; d_wd = 64'h55; d_mask = 64'hFF; d_type = 2'b01;
        step();
        dv = 1'b0; iv = 1'b1; i_idx = 64'h8000_0080; i_type = 2'b00;
        for (int k = 0; k < 5; k++) begin
            d_idx = {$urandom, $urandom};
            step();
        end
        set_ddr(1'b1, 1'b0, 64'h0); step();
        set_ddr(1'b0, 1'b1, 64'h77); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();
        // Same-cycle ready and done with icache pending behind it.
        set_ddr(1'b1, 1'b1, 64'h99); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();
        iv = 1'b0;
        set_ddr(1'b1, 1'b1, 64'h1234); step();

        // Spurious done while idle.
        set_ddr(1'b0, 1'b1, 64'hFFFF); step(); step();
        set_ddr(1'b0, 1'b0, 64'h0);

        // Reset in the middle of a dcache WAIT_DONE.
        dv = 1'b1; d_idx = 64'h8000_3000; d_type = 2'b00; step();
        dv = 1'b0; set_ddr(1'b1, 1'b0, 64'h0); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();
        reset_n = 1'b0; iv = 1'b1; dv = 1'b1;
        set_ddr(1'b0, 1'b1, 64'hBAD);
        model_reset();
        #1 check_all();
        step();
        reset_n = 1'b1; dv = 1'b0;
        i_idx = 64'h8000_0040; i_type = 2'b00;
        set_ddr(1'b0, 1'b0, 64'h0); step();
        iv = 1'b0; set_ddr(1'b1, 1'b0, 64'h0); step();
        set_ddr(1'b0, 1'b1, 64'hC0FF_EE00_0000_0040); step();
        set_ddr(1'b0, 1'b0, 64'h0); step();

        // Randomized traffic, including occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            iv = ($urandom_range(0, 1) == 1);
            dv = ($urandom_range(0, 1) == 1);
            i_idx = {$urandom, $urandom}; i_wd = {$urandom, $urandom};
            i_mask = {$urandom, $urandom}; i_type = 2'($urandom_range(0, 1));
            d_idx = {$urandom, $urandom}; d_wd = {$urandom, $urandom};
            d_mask = {$urandom, $urandom}; d_type = 2'($urandom_range(0, 1));
            set_ddr($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, {$urandom, $urandom});
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end else begin
                reset_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tbus_arbiter.md
# tbus_arbiter

Two-way round-robin arbiter that shares the single DDR-side trinity bus between the icache and dcache miss/writeback ports. It accepts one request at a time, forwards it downstream, waits for completion, and steers read data and the done pulse back to the owner. It sits between the `*2arb_tbus_*` outputs of both caches and the DDR controller's trinity bus slave port.

## Interface
- No parameters; widths come from the shared package: `RESULT_RANGE` = 64 bits, `SRC_RANGE` = 64 bits, `TBUS_RANGE` = 2 bits.
- `clock` in 1 — single clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- In each port line below, `X` is `icache` or `dcache`, giving one port per requester.
- `X2arb_tbus_index_valid` in 1 — request valid.
- `X2arb_tbus_index_ready` out 1 — request accepted this cycle.
- `X2arb_tbus_index` in 64 — physical address.
- `X2arb_tbus_write_data` in 64 — write data.
- `X2arb_tbus_write_mask` in 64 — bit write mask.
- `X2arb_tbus_operation_type` in 2 — `TBUS_READ` / `TBUS_WRITE`.
- `X2arb_tbus_read_data` out 64 — read data, valid with done.
- `X2arb_tbus_operation_done` out 1 — one-cycle completion pulse.
- `ddr_tbus_index_valid` out 1 — downstream request valid.
- `ddr_tbus_index_ready` in 1 — downstream accept.
- `ddr_tbus_index` out 64 — latched address.
- `ddr_tbus_write_data` out 64 — latched write data.
- `ddr_tbus_write_mask` out 64 — latched mask.
- `ddr_tbus_operation_type` out 2 — latched type.
- `ddr_tbus_read_data` in 64 — downstream read data.
- `ddr_tbus_operation_done` in 1 — downstream completion pulse.

## Operation
- FSM states:
  - `IDLE`: `index_ready` is driven only to the pick winner, and only while that requester's valid is high. On the valid & ready handshake: latch index, write_data, write_mask and operation_type, record the owner, then go to `ISSUE`.
  - `ISSUE`: `ddr_tbus_index_valid`=1 with the latched fields, held stable until `ddr_tbus_index_ready`. On ready go to `WAIT_DONE`; if `ddr_tbus_operation_done` is also high in that cycle, complete immediately and go to `IDLE`.
  - `WAIT_DONE`: on `ddr_tbus_operation_done`, pulse the owner's `operation_done` and drive the owner's `read_data` from `ddr_tbus_read_data` (combinational pass-through, same cycle), then go to `IDLE`.
- Pick rule in `IDLE`:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - The `last_grant` bit updates only on an accepted handshake; its reset value is icache, so dcache wins the first tie.
- Non-owner outputs are always 0; `read_data` is 0 whenever `operation_done` is 0.
- Write requests still complete with a done pulse; their `read_data` is passed through but has no meaning.
- `ddr_tbus_operation_done` seen in `IDLE` is ignored; it raises no pulse.
- Requester valid deasserting in `ISSUE`/`WAIT_DONE` has no effect; the latched request completes.

## Timing
- Reset (asynchronous, any state): FSM → `IDLE`, latches and owner cleared, `last_grant`=icache.
  - Every output reads 0 during reset.
  - After reset, `index_ready` is 0 until a valid is seen.
  - An in-flight DDR transaction is abandoned; the DDR side must be reset together with the arbiter.
- Handshake in cycle T → `ddr_tbus_index_valid` high from T+1 (driven from registers).
- DDR ready and done both in T+1 → owner done in T+1, `IDLE` in T+2, next accept possible in T+2. This is a minimum 2-cycle occupancy.
- Done in cycle D of `WAIT_DONE` → owner pulse in D, `IDLE` in D+1.
- No request pipelining: at most one outstanding transaction.
- `index_ready` depends combinationally on the valids and the state; no ready-to-valid loop is permitted in requesters.

## Structure
- Shared package (`tbus_defs`): `TBUS_READ`, `TBUS_WRITE`, `RESULT_RANGE`, `SRC_RANGE`, `TBUS_RANGE`, and the FSM state encodings (`IDLE`=2'b00, `ISSUE`=2'b01, `WAIT_DONE`=2'b10).
- One sub-module, `tbus_rr_pick`:
  - Inputs: 2-bit req vector and `last_grant`.
  - Output: one-hot grant.
  - Purely combinational.
- The FSM, request latches and return steering are in the top module.

## Test plan
- Reset mid-`WAIT_DONE` with dcache owning: all outputs 0 immediately; after release, icache read to 0x8000_0040 is accepted and completes normally.
- dcache read of 0x8000_1000 alone, DDR ready at T+1, done at T+3 with data 0xDEAD_BEEF_0123_4567 → `dcache2arb_tbus_operation_done` pulse at T+3 with that data; icache outputs stay 0.
- Both valid at the first cycle after reset → dcache granted; both held valid → icache, dcache, icache grants alternate.
- dcache write (index 0x8000_2000, data 0x55, mask 0xFF) with DDR ready held low for 5 cycles → DDR index/data/mask/type stable all 5 cycles, no upstream ready until completion.
- DDR ready and done in the same cycle → done pulse in that cycle, `IDLE` next cycle, a pending icache request accepted that cycle.
- Spurious `ddr_tbus_operation_done` while `IDLE` → no done pulse on either requester.
